// File: rtl/clk_switch_seq_pkg.sv
// clk_switch_pkg
// Shared types and encodings for the clock-switch sequencer.
//   state_t : sequencer FSM states
//   SRC_A / SRC_B : encoding of the selected clock source on sel_out / req_sel
package clk_switch_pkg;

    // The S_ prefix keeps S_GUARD from colliding with the GUARD parameter.
    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_ISSUE        = 3'd1,
        S_WAIT_ASSERT  = 3'd2,
        S_WAIT_RELEASE = 3'd3,
        S_GUARD        = 3'd4
    } state_t;

    localparam logic SRC_A = 1'b1;
    localparam logic SRC_B = 1'b0;

endpackage

// File: rtl/clk_switch_seq_if.sv
// clk_switch_seq_if
// Bundles the requester handshake, the clock-select control/feedback and the
// error flag of clk_switch_seq.
//   master : environment side (requesters, select block feedback, err_clr)
//   slave  : the sequencer
interface clk_switch_seq_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] req_sel;
    logic [NREQ-1:0] ack;
    logic            ack_err;
    logic            sel_out;
    logic            sel_en;
    logic            sel_rst_in;
    logic            busy;
    logic            timeout_err;
    logic            err_clr;

    modport master (
        output req, req_sel, sel_rst_in, err_clr,
        input  ack, ack_err, sel_out, sel_en, busy, timeout_err
    );

    modport slave (
        input  req, req_sel, sel_rst_in, err_clr,
        output ack, ack_err, sel_out, sel_en, busy, timeout_err
    );
endinterface

// File: rtl/clk_switch_seq_sync2.sv
// sync2
// Two-flop single-bit synchronizer with a configurable reset value.
//   CLK, RST : destination clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/clk_switch_seq.sv
// clk_switch_seq
// Round-robin arbiter and sequencer for a two-source clock-select block.
// Grants one source-change request at a time, pulses SELECT_ENABLE, follows
// the select block's output reset through assert and release, then acks.
//   CLK, RST : control clock, synchronous active-high reset
//   bus      : requester handshake, select control/feedback, error flag
//
// state          | meaning
// S_IDLE         | arbitrating; same-source requests acked directly
// S_ISSUE        | sel_en pulse cycle; timer cleared
// S_WAIT_ASSERT  | waiting for the select block's output reset to assert
// S_WAIT_RELEASE | waiting for the output reset to release
// S_GUARD        | enforced idle gap after a switch, requests ignored
module clk_switch_seq
    import clk_switch_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int TIMEOUT  = 256,
    parameter int GUARD    = 4,
    parameter int ORST_LOW = 1
) (
    input  logic               CLK,
    input  logic               RST,
    clk_switch_seq_if.slave    bus
);
    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int GW = $clog2(GUARD + 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GLAST = GW'((GUARD > 0) ? GUARD - 1 : 0);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gidx;
    logic [TW-1:0]   timer;
    logic [GW-1:0]   gcnt;
    logic [NREQ-1:0] ack_q;
    logic            ack_err_q;
    logic            sel_out_q;
    logic            sel_en_q;
    logic            busy_q;
    logic            terr_q;

    logic            rst_sync;
    logic            rs;
    logic [IW-1:0]   g;
    logic            any_req;

    // Reset value is the raw "deasserted" level so rs reads 0 out of reset.
    sync2 #(.RST_VAL((ORST_LOW != 0) ? 1'b1 : 1'b0)) u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (bus.sel_rst_in),
        .q   (rst_sync)
    );

    assign rs = (ORST_LOW != 0) ? ~rst_sync : rst_sync;

    // First requester strictly after 'last', wrapping around.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   last);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(last) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && r[IW'(idx)]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
        return pick;
    endfunction

    assign g       = rr_pick(bus.req, ptr);
    assign any_req = |bus.req;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            ptr       <= IW'(NREQ - 1);
            gidx      <= '0;
            timer     <= '0;
            gcnt      <= '0;
            ack_q     <= '0;
            ack_err_q <= 1'b0;
            sel_out_q <= SRC_B;
            sel_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            ack_q     <= '0;
            ack_err_q <= 1'b0;
            sel_en_q  <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (bus.err_clr) terr_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Holding off while ack is up keeps a still-high req from
                    // being granted twice.
                    if (any_req && (ack_q == '0)) begin
                        ptr <= g;
                        if (bus.req_sel[g] == sel_out_q) begin
                            ack_q[g] <= 1'b1;
                        end else begin
                            gidx      <= g;
                            sel_out_q <= bus.req_sel[g];
                            sel_en_q  <= 1'b1;
                            busy_q    <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT_ASSERT;
                end
                S_WAIT_ASSERT: begin
                    if (rs) begin
                        timer <= '0;
                        state <= S_WAIT_RELEASE;
                    end else if (timer == TMAX) begin
                        ack_q[gidx] <= 1'b1;
                        ack_err_q   <= 1'b1;
                        terr_q      <= 1'b1;
                        gcnt        <= GLAST;
                        state       <= S_GUARD;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WAIT_RELEASE: begin
                    if (!rs) begin
                        ack_q[gidx] <= 1'b1;
                        gcnt        <= GLAST;
                        state       <= S_GUARD;
                    end else if (timer == TMAX) begin
                        ack_q[gidx] <= 1'b1;
                        ack_err_q   <= 1'b1;
                        terr_q      <= 1'b1;
                        gcnt        <= GLAST;
                        state       <= S_GUARD;
                    end else if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                end
                S_GUARD: begin
                    if (gcnt == '0) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        gcnt <= gcnt - GW'(1);
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack         = ack_q;
    assign bus.ack_err     = ack_err_q;
    assign bus.sel_out     = sel_out_q;
    assign bus.sel_en      = sel_en_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
endmodule
